transpose_drain_buffer: RTL and testbench

TRANSPOSE_DRAIN_BUFFER -- requirements
Module: transpose_drain_buffer

---
 rtl/transpose_drain_buffer.sv | 96 +++++++++
 tb/tb_transpose_drain_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/transpose_drain_buffer.sv
// Ping-pong transpose buffer: rows of an NUM_PE x NUM_PE matrix fill one bank
// while the other bank drains the previously completed matrix column by column.
module transpose_drain_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_row [0:NUM_PE-1],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_col [0:NUM_PE-1],
    output logic [$clog2(NUM_PE)-1:0]   out_col_idx,
    output logic                        out_last
);

    localparam int CW = $clog2(NUM_PE);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PE - 1);
    localparam logic [CW-1:0] IDX_ONE  = CW'(32'd1);

    logic [DATA_WIDTH-1:0] bank_r [0:1][0:NUM_PE-1][0:NUM_PE-1];
    logic [1:0]            full_r;
    logic                  wb_r;
    logic                  rb_r;
    logic [CW-1:0]         wr_cnt_r;
    logic [CW-1:0]         rd_cnt_r;
    logic                  accept_s;
    logic                  drain_s;

    // A bank that is still full blocks writes; this never looks at in_valid.
    assign in_ready = !full_r[wb_r];
    assign accept_s = in_valid && in_ready;
    assign drain_s  = full_r[rb_r] && out_ready;

    // Row capture into the filling bank (storage carries no reset).
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int c = 0; c < NUM_PE; c++) begin
                bank_r[wb_r][wr_cnt_r][c] <= in_row[c];
            end
        end
    end

    // Fill/drain bookkeeping; accept and drain always target different banks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r   <= 2'b00;
            wb_r     <= 1'b0;
            rb_r     <= 1'b0;
            wr_cnt_r <= '0;
            rd_cnt_r <= '0;
        end else begin
            if (accept_s) begin
                if (wr_cnt_r == LAST_IDX) begin
                    full_r[wb_r] <= 1'b1;
                    wr_cnt_r     <= '0;
                    wb_r         <= ~wb_r;
                end else begin
                    wr_cnt_r <= wr_cnt_r + IDX_ONE;
                end
            end
            if (drain_s) begin
                if (rd_cnt_r == LAST_IDX) begin
                    full_r[rb_r] <= 1'b0;
                    rd_cnt_r     <= '0;
                    rb_r         <= ~rb_r;
                end else begin
                    rd_cnt_r <= rd_cnt_r + IDX_ONE;
                end
            end
        end
    end

    // Column read mux straight off registered state; zeroed when nothing is presented.
    always_comb begin
        out_valid   = full_r[rb_r];
        out_col_idx = '0;
        out_last    = 1'b0;
        for (int r = 0; r < NUM_PE; r++) begin
            out_col[r] = '0;
        end
        if (full_r[rb_r]) begin
            out_col_idx = rd_cnt_r;
            out_last    = (rd_cnt_r == LAST_IDX);
            for (int r = 0; r < NUM_PE; r++) begin
                out_col[r] = bank_r[rb_r][r][rd_cnt_r];
            end
        end else begin
            out_col_idx = '0;
            out_last    = 1'b0;
        end
    end

endmodule

// File: tb/tb_transpose_drain_buffer.sv
// Directed bench for transpose_drain_buffer; element (m,r,c) = 256*m + 16*r + c.
module tb_transpose_drain_buffer;

    localparam int NP = 8;
    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_row [0:NP-1];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_col [0:NP-1];
    logic [2:0]    out_col_idx;
    logic          out_last;

    int vec_cnt;
    int err_cnt;

    transpose_drain_buffer #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_col    (out_col),
        .out_col_idx(out_col_idx),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] elem(input int m, input int r, input int c);
        return 64'(m * 256 + 16 * r + c);
    endfunction

    task automatic set_row(input int m, input int r);
        for (int c = 0; c < NP; c++) in_row[c] = elem(m, r, c);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_value({tag, "_in_ready"}, in_ready, 1);
        check_value({tag, "_out_valid"}, out_valid, 0);
        check_value({tag, "_idx"}, out_col_idx, 0);
        check_value({tag, "_last"}, out_last, 0);
        for (int r = 0; r < NP; r++) check_value({tag, "_col_zero"}, out_col[r], 0);
    endtask

    task automatic send_partial(input int n);
        out_ready = 1'b0;
        for (int r = 0; r < n; r++) begin
            in_valid = 1'b1;
            set_row(9, r);
            @(negedge clk);
        end
    endtask

    // mode 0: out_ready high, 1: random out_ready, 2: hold off until both banks full
    task automatic run_traffic(input int n_mats, input int mode, input int first_mat);
        int total;
        int rows_sent;
        int cols_done;
        int hold;
        int m;
        int col;
        bit reopen_done;
        bit stalled;
        logic [2:0]    held_idx;
        logic [DW-1:0] held_col [0:NP-1];
        total = n_mats * NP;
        rows_sent = 0;
        cols_done = 0;
        hold = 0;
        reopen_done = 1'b0;
        stalled = 1'b0;
        held_idx = 3'd0;
        for (int r = 0; r < NP; r++) held_col[r] = '0;
        for (int cyc = 0; cyc < 600 && (rows_sent < total || cols_done < total); cyc++) begin
            @(negedge clk);
            if (stalled) begin
                check_value("stall_idx", out_col_idx, held_idx);
                for (int r = 0; r < NP; r++) check_value("stall_col", out_col[r], held_col[r]);
            end
            if (rows_sent < NP) check_value("early_valid", out_valid, 0);
            else if (cols_done == 0) check_value("fill_latency", out_valid, 1);
            if (mode == 0) begin
                if (rows_sent < total) check_value("stream_in_ready", in_ready, 1);
                if (cols_done > 0 && cols_done < total) check_value("stream_no_bubble", out_valid, 1);
            end
            if (mode == 2) begin
                if (rows_sent == 2 * NP && cols_done < NP) begin
                    check_value("bp_in_ready_low", in_ready, 0);
                    hold++;
                end
                if (cols_done == NP && !reopen_done) begin
                    check_value("bp_reopen", in_ready, 1);
                    reopen_done = 1'b1;
                end
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (hold >= 4);
                default: out_ready = 1'b1;
            endcase
            if (rows_sent < total) begin
                in_valid = 1'b1;
                set_row(first_mat + rows_sent / NP, rows_sent % NP);
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) rows_sent++;
            stalled = out_valid && !out_ready;
            if (stalled) begin
                held_idx = out_col_idx;
                for (int r = 0; r < NP; r++) held_col[r] = out_col[r];
            end
            if (out_valid && out_ready) begin
                m = first_mat + cols_done / NP;
                col = cols_done % NP;
                check_value("xfer_idx", out_col_idx, col);
                check_value("xfer_last", out_last, (col == NP - 1) ? 1 : 0);
                for (int r = 0; r < NP; r++) check_value("xfer_data", out_col[r], elem(m, r, col));
                cols_done++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_value("rows_accepted", rows_sent, total);
        check_value("cols_drained", cols_done, total);
        check_value("idle_after", out_valid, 0);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < NP; c++) in_row[c] = '0;

        do_reset("init");

        // Single matrix with output held off, then stepped column by column
        for (int r = 0; r < NP; r++) begin
            check_value("single_early", out_valid, 0);
            check_value("single_in_ready", in_ready, 1);
            in_valid = 1'b1;
            set_row(0, r);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_value("single_valid", out_valid, 1);
        check_value("single_in_ready_after", in_ready, 1);
        check_value("single_idx0", out_col_idx, 0);
        check_value("single_c5_r0", out_col[5], 64'h50);
        check_value("single_last0", out_last, 0);
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_value("single_idx3", out_col_idx, 3);
        check_value("single_c5_r3", out_col[5], 64'h53);
        @(negedge clk);
        check_value("single_hold_idx3", out_col_idx, 3);
        check_value("single_hold_c5", out_col[5], 64'h53);
        for (int k = 3; k < NP; k++) begin
            check_value("single_step_idx", out_col_idx, k);
            check_value("single_step_last", out_last, (k == NP - 1) ? 1 : 0);
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_value("single_drained", out_valid, 0);

        run_traffic(3, 0, 0);
        run_traffic(3, 2, 3);
        run_traffic(4, 1, 10);

        send_partial(10);
        do_reset("rst_mid");

        send_partial(5);
        do_reset("rst_fill");
        run_traffic(1, 0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
